dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Responder (memory side) of the processor's data-memory interface. It accepts read/write requests from the CPU core over a ready/valid handshake, applies a configurable access latency, and returns one response per request. It also exposes a combinational debug read port so board switches and displays can inspect memory contents. It replaces the zero-wait data memory in the top level.

Parameters:
DATA_W, 4, word width in bits.
ADDR_W, 4, address width; depth is 2**ADDR_W words.
LATENCY, 2, wait cycles between acceptance and response; legal range 0..7.

Ports:
clk  in  1  system clock (the divided clock at top level).
reset  in  1  asynchronous reset, active-low.
req_we  in  1  write request.
req_re  in  1  read request.
req_addr  in  ADDR_W  request address.
req_wdata  in  DATA_W  write data.
req_ready  out  1  high when a new request can be accepted.
rsp_valid  out  1  one-cycle pulse marking the response.
rsp_rdata  out  DATA_W  read data; valid only while rsp_valid is high.
rsp_err  out  1  error flag; valid only while rsp_valid is high.
dbg_addr  in  ADDR_W  debug read address.
dbg_data  out  DATA_W  combinational read of mem[dbg_addr].

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All memory words are cleared to 0.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- FSM states and transitions:
  - IDLE: req_ready=1. A request is accepted at a rising edge when req_we or req_re is high. On acceptance, the address, wdata and op are captured and the wait counter is loaded with LATENCY. Next state is WAIT if LATENCY>0, else RESP.
  - WAIT: req_ready=0. The counter decrements each cycle. When the counter reaches 1, next state is RESP.
  - RESP: req_ready=0 and rsp_valid=1 for exactly one cycle. Next state is IDLE.
- Commit timing:
  - The write commits, and read data is registered into rsp_rdata, on the edge that enters RESP.
  - rsp_valid is therefore seen LATENCY+1 cycles after the accepting edge.
  - Throughput is one request per LATENCY+2 cycles.
- Request inputs are ignored whenever req_ready=0. The initiator must hold its request until it is accepted.
- If req_we and req_re are both high at acceptance:
  - no write is performed;
  - rsp_rdata=0 and rsp_err=1 in RESP.
- Any legal read or write gives rsp_err=0. A write response returns rsp_rdata=0.
- Read-after-write to the same address in back-to-back transactions returns the new data.
- dbg_data reflects a committed write from the cycle after the commit edge.
- Reset asserted during WAIT or RESP aborts the transaction: no write is committed and no response is produced.
- Address wrap is not applicable, since the full ADDR_W range is implemented.
- The counter is 3 bits wide. LATENCY>7 is a configuration error.

Optional Feature:
Macro DMEM_PARITY_EN.
- With the macro defined:
  - each word stores an extra even-parity bit, written at commit;
  - a new input par_inject (1 bit) inverts the stored parity bit on a write, for test use;
  - on a read, a parity mismatch sets rsp_err=1 and rsp_rdata still returns the stored data;
  - reset clears the parity bits to 0, which is consistent with all-zero data.
- Without the macro: no parity storage, no par_inject port, and rsp_err is raised only for the we+re conflict.

Decomposition:
- Shared package dmem_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the defaults DMEM_DATA_W=4, DMEM_ADDR_W=4 and DMEM_LAT_W=3.
- One sub-module, dmem_array: the storage, with an asynchronous active-low clear, one synchronous write port and two combinational read ports (access and debug). It also holds the parity bits when DMEM_PARITY_EN is defined.
- The FSM and counter stay in dmem_responder.

Test Plan:
1. LATENCY=2; after reset, write addr 5 data 0xA → rsp_valid at the 3rd edge after acceptance, rsp_err=0, dbg_addr=5 gives 0xA; req_ready is low for 3 cycles.
2. Read addr 5 → rsp_rdata=0xA with rsp_valid; read an unwritten addr 3 → 0x0.
3. req_we=req_re=1 at addr 7 with wdata 0xF → rsp_err=1, rsp_rdata=0, mem[7] stays 0.
4. Change addr to 9 and wdata to 0x3 while in WAIT → ignored; only the originally captured transaction commits.
5. Assert reset mid-WAIT of a write of 0xC to addr 2 → no rsp_valid; after release, dbg_data at addr 2 is 0 and req_ready=1.
6. LATENCY=0 → rsp_valid 1 cycle after acceptance. With DMEM_PARITY_EN, write 0x6 with par_inject=1, then read → rsp_err=1, rsp_rdata=0x6.

Source files
------------

// File: rtl/dmem_pkg.sv
//------------------------------------------------------------------------------
// dmem_pkg
//   Shared types and default sizes for the data-memory responder slice.
//   - state_t     : responder FSM states (IDLE, WAIT, RESP)
//   - DMEM_DATA_W : default word width
//   - DMEM_ADDR_W : default address width (depth = 2**DMEM_ADDR_W)
//   - DMEM_LAT_W  : width of the latency wait counter (LATENCY range 0..7)
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_pkg;

  localparam int DMEM_DATA_W = 4;
  localparam int DMEM_ADDR_W = 4;
  localparam int DMEM_LAT_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage : dmem_pkg

`default_nettype wire

// File: rtl/dmem_array.sv
//------------------------------------------------------------------------------
// dmem_array
//   Word storage for the data-memory responder: asynchronous active-low clear
//   of every word, one synchronous write port, and two combinational read
//   ports (access and debug).
//   Optional macro DMEM_PARITY_EN: each word carries an even-parity bit that
//   is written with the data; par_flip_i inverts the stored bit for fault
//   injection, and rpar_err_o flags a parity mismatch on the access port.
//
// Ports:
//   clk         in   clock
//   reset       in   asynchronous clear, active-low
//   we_i        in   write enable
//   waddr_i     in   write address
//   wdata_i     in   write data
//   par_flip_i  in   invert stored parity on this write (DMEM_PARITY_EN only)
//   rpar_err_o  out  parity mismatch at raddr_i (DMEM_PARITY_EN only)
//   raddr_i     in   access read address
//   rdata_o     out  mem[raddr_i]
//   dbg_addr_i  in   debug read address
//   dbg_data_o  out  mem[dbg_addr_i]
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = DMEM_DATA_W,
  parameter int ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef DMEM_PARITY_EN
  input  logic              par_flip_i,
  output logic              rpar_err_o,
`endif
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o    = mem_q[raddr_i];
  assign dbg_data_o = mem_q[dbg_addr_i];

`ifdef DMEM_PARITY_EN
  // Cleared parity of 0 matches all-zero data, so a freshly reset word reads clean.
  logic [DEPTH-1:0] par_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= '0;
    end else if (we_i) begin
      par_q[waddr_i] <= (^wdata_i) ^ par_flip_i;
    end
  end

  assign rpar_err_o = (^mem_q[raddr_i]) != par_q[raddr_i];
`endif

endmodule : dmem_array

`default_nettype wire

// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// dmem_responder
//   Memory-side responder of the CPU data-memory interface. Accepts one
//   read/write request at a time over a ready/valid handshake, waits LATENCY
//   cycles, then returns a single-cycle response. A combinational debug port
//   reads any word for board-level inspection.
//   Optional macro DMEM_PARITY_EN adds per-word parity, the par_inject input
//   and parity-error reporting on reads.
//
// Parameters:
//   DATA_W   word width
//   ADDR_W   address width (depth 2**ADDR_W)
//   LATENCY  wait cycles between acceptance and response, 0..7
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous reset, active-low
//   req_we      in   write request
//   req_re      in   read request
//   req_addr    in   request address
//   req_wdata   in   write data
//   par_inject  in   invert stored parity on a write (DMEM_PARITY_EN only)
//   req_ready   out  new request can be accepted
//   rsp_valid   out  one-cycle response strobe
//   rsp_rdata   out  read data (meaningful while rsp_valid)
//   rsp_err     out  error flag (meaningful while rsp_valid)
//   dbg_addr    in   debug read address
//   dbg_data    out  mem[dbg_addr], combinational
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_we,
  input  logic              req_re,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_PARITY_EN
  input  logic              par_inject,
`endif
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  // Counter is DMEM_LAT_W bits; LATENCY above 7 is a configuration error.
  localparam logic [DMEM_LAT_W-1:0] C_LAT = DMEM_LAT_W'(LATENCY);

  state_t                state_q, state_d;
  logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic                  we_q;
  logic                  re_q;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
`ifdef DMEM_PARITY_EN
  logic                  inj_q;
`endif

  logic                  accept;
  logic                  in_idle;
  logic                  enter_resp;
  logic [ADDR_W-1:0]     op_addr;
  logic [DATA_W-1:0]     op_wdata;
  logic                  op_we;
  logic                  op_re;
  logic                  op_conflict;
  logic                  mem_we;
  logic [DATA_W-1:0]     arr_rdata;
  logic                  par_err;

  assign in_idle = (state_q == IDLE);
  assign accept  = in_idle && (req_we || req_re);

  // The commit happens on the edge entering RESP. With LATENCY=0 that is the
  // accepting edge itself, so the live request is used while still in IDLE;
  // otherwise the captured copy is used.
  assign op_addr     = in_idle ? req_addr  : addr_q;
  assign op_wdata    = in_idle ? req_wdata : wdata_q;
  assign op_we       = in_idle ? req_we    : we_q;
  assign op_re       = in_idle ? req_re    : re_q;
  assign op_conflict = op_we && op_re;

  assign enter_resp = (state_d == RESP);
  assign mem_we     = enter_resp && op_we && !op_re;

  //--------------------------------------------------------------------------
  // Storage
  //--------------------------------------------------------------------------
`ifdef DMEM_PARITY_EN
  logic op_inj;
  assign op_inj = in_idle ? par_inject : inj_q;
`endif

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .we_i       (mem_we),
    .waddr_i    (op_addr),
    .wdata_i    (op_wdata),
`ifdef DMEM_PARITY_EN
    .par_flip_i (op_inj),
    .rpar_err_o (par_err),
`endif
    .raddr_i    (op_addr),
    .rdata_o    (arr_rdata),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

`ifndef DMEM_PARITY_EN
  assign par_err = 1'b0;
`endif

  //--------------------------------------------------------------------------
  // FSM: state register
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  //--------------------------------------------------------------------------
  // FSM: next state
  //--------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_we || req_re) begin
          state_d = (C_LAT == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        // <= also covers a zero count, which cannot occur, to avoid a stuck state.
        if (cnt_q <= DMEM_LAT_W'(1)) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  //--------------------------------------------------------------------------
  // FSM: outputs
  //--------------------------------------------------------------------------
  always_comb begin
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      RESP:    rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  //--------------------------------------------------------------------------
  // Wait counter and response data
  //--------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = C_LAT;
    end else if (state_q == WAIT) begin
      cnt_d = cnt_q - DMEM_LAT_W'(1);
    end
  end

  // Response registers are only non-zero during RESP.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (enter_resp) begin
      if (op_conflict) begin
        err_d = 1'b1;
      end else if (op_re) begin
        rdata_d = arr_rdata;
        err_d   = par_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        we_q    <= req_we;
        re_q    <= req_re;
      end
    end
  end

`ifdef DMEM_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inj_q <= 1'b0;
    end else if (accept) begin
      inj_q <= par_inject;
    end
  end
`endif

endmodule : dmem_responder

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// tb_dmem_responder
//   Scoreboard bench for dmem_responder. Two instances: LATENCY=2 (dut0) and
//   LATENCY=0 (dut1). The driver pushes the expected response of every
//   accepted request into a queue; a negedge monitor pops and compares.
//   Build with DMEM_PARITY_EN to exercise the parity feature.
// Revision: 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

  localparam int LAT0 = 2;
  localparam int LAT1 = 0;
`ifdef DMEM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    int dut;
    int due;
    int rdata;
    int err;
    int dbg_exp;
  } item_t;

  logic       clk;
  logic       reset;
  logic [1:0] we_s, re_s;
  logic [3:0] addr_s  [2];
  logic [3:0] wdata_s [2];
  logic [3:0] dbga    [2];
  logic [1:0] rdy, vld, err;
  logic [3:0] rdata   [2];
  logic [3:0] dbg     [2];
`ifdef DMEM_PARITY_EN
  logic [1:0] inj_s;
`endif

  int    cyc = 0;
  int    n_checks = 0;
  int    n_errors = 0;
  item_t exp_q[$];

  // Reference memory content and "parity corrupted" marker per word.
  logic [3:0] mdl [2][16];
  bit         bad [2][16];

  dmem_responder #(.DATA_W(4), .ADDR_W(4), .LATENCY(LAT0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .req_we    (we_s[0]),
    .req_re    (re_s[0]),
    .req_addr  (addr_s[0]),
    .req_wdata (wdata_s[0]),
`ifdef DMEM_PARITY_EN
    .par_inject(inj_s[0]),
`endif
    .req_ready (rdy[0]),
    .rsp_valid (vld[0]),
    .rsp_rdata (rdata[0]),
    .rsp_err   (err[0]),
    .dbg_addr  (dbga[0]),
    .dbg_data  (dbg[0])
  );

  dmem_responder #(.DATA_W(4), .ADDR_W(4), .LATENCY(LAT1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .req_we    (we_s[1]),
    .req_re    (re_s[1]),
    .req_addr  (addr_s[1]),
    .req_wdata (wdata_s[1]),
`ifdef DMEM_PARITY_EN
    .par_inject(inj_s[1]),
`endif
    .req_ready (rdy[1]),
    .rsp_valid (vld[1]),
    .rsp_rdata (rdata[1]),
    .rsp_err   (err[1]),
    .dbg_addr  (dbga[1]),
    .dbg_data  (dbg[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int d, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", nm, d, act, expv, cyc);
    end
  endtask

  //--------------------------------------------------------------------------
  // Monitor / scoreboard
  //--------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    bit    pend;
    item_t it;
    for (int d = 0; d < 2; d++) begin
      if (!reset) begin
        chk("rst_ready", d, int'(rdy[d]), 1);
        chk("rst_valid", d, int'(vld[d]), 0);
        chk("rst_rdata", d, int'(rdata[d]), 0);
        chk("rst_err",   d, int'(err[d]), 0);
        chk("rst_dbg",   d, int'(dbg[d]), 0);
      end else begin
        pend = (exp_q.size() > 0) && (exp_q[0].dut == d);
        chk("ready", d, int'(rdy[d]), pend ? 0 : 1);
        if (pend) begin
          if (vld[d] || cyc >= exp_q[0].due) begin
            it = exp_q.pop_front();
            chk("rsp_valid", d, int'(vld[d]), 1);
            chk("latency",   d, cyc, it.due);
            chk("rsp_rdata", d, int'(rdata[d]), it.rdata);
            chk("rsp_err",   d, int'(err[d]), it.err);
            chk("dbg_data",  d, int'(dbg[d]), it.dbg_exp);
          end else begin
            chk("early_valid", d, int'(vld[d]), 0);
          end
        end else begin
          chk("spurious_valid", d, int'(vld[d]), 0);
        end
      end
    end
  end

  //--------------------------------------------------------------------------
  // Driver helpers
  //--------------------------------------------------------------------------
  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++) begin
        mdl[d][a] = 4'h0;
        bad[d][a] = 1'b0;
      end
    end
  endtask

  task automatic idle_inputs(input int d);
    we_s[d]    = 1'b0;
    re_s[d]    = 1'b0;
    addr_s[d]  = 4'h0;
    wdata_s[d] = 4'h0;
`ifdef DMEM_PARITY_EN
    inj_s[d]   = 1'b0;
`endif
  endtask

  // Random garbage on the request lines while the responder is busy.
  task automatic junk(input int d);
    we_s[d]    = 1'($urandom_range(0, 1));
    re_s[d]    = 1'($urandom_range(0, 1));
    addr_s[d]  = 4'($urandom_range(0, 15));
    wdata_s[d] = 4'($urandom_range(0, 15));
`ifdef DMEM_PARITY_EN
    inj_s[d]   = 1'($urandom_range(0, 1));
`endif
  endtask

  // Called just after a rising edge with the target instance idle.
  task automatic txn(input int d, input bit we, input bit re, input int addr,
                     input int wdata, input bit inj, input bit abort);
    item_t it;
    int    pre;
    we_s[d]    = we;
    re_s[d]    = re;
    addr_s[d]  = 4'(addr);
    wdata_s[d] = 4'(wdata);
    dbga[d]    = 4'(addr);
`ifdef DMEM_PARITY_EN
    inj_s[d]   = inj;
`endif
    it.dut = d;
    if (we && re) begin
      it.rdata = 0;
      it.err   = 1;
    end else if (we) begin
      it.rdata      = 0;
      it.err        = 0;
      mdl[d][addr]  = 4'(wdata);
      bad[d][addr]  = PAR && inj;
    end else begin
      it.rdata = int'(mdl[d][addr]);
      it.err   = bad[d][addr] ? 1 : 0;
    end
    it.dbg_exp = int'(mdl[d][addr]);

    @(negedge clk);
    pre    = cyc;
    it.due = pre + 1 + ((d == 0) ? LAT0 : LAT1);
    @(posedge clk);
    exp_q.push_back(it);
    #1;
    if (abort) begin
      junk(d);
      @(posedge clk);
      #1;
      exp_q.delete();
      clear_model();
      reset = 1'b0;
      idle_inputs(d);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      return;
    end
    for (int k = 0; exp_q.size() != 0; k++) begin
      if (k > 12) begin
        $display("FAIL response_timeout dut%0d: got no rsp_valid expected one by cycle %0d", d, it.due);
        $fatal(1, "response timeout");
      end
      junk(d);
      @(posedge clk);
      #1;
    end
    idle_inputs(d);
  endtask

  task automatic rand_txns(input int d, input int n);
    int op;
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 5);
      txn(d, (op <= 1) || (op == 4), (op >= 2), $urandom_range(0, 15),
          $urandom_range(0, 15), ($urandom_range(0, 3) == 0), 1'b0);
    end
  endtask

  //--------------------------------------------------------------------------
  // Stimulus
  //--------------------------------------------------------------------------
  initial begin
    reset = 1'b0;
    clear_model();
    for (int d = 0; d < 2; d++) begin
      idle_inputs(d);
      dbga[d] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // LATENCY=2 instance: directed cases
    txn(0, 1, 0, 5, 4'hA, 0, 0);   // write 5 <- A
    txn(0, 0, 1, 5, 0,    0, 0);   // read 5 -> A
    txn(0, 0, 1, 3, 0,    0, 0);   // unwritten -> 0
    txn(0, 1, 1, 7, 4'hF, 0, 0);   // we+re conflict
    txn(0, 0, 1, 7, 0,    0, 0);   // mem[7] untouched
    txn(0, 1, 0, 9, 4'h3, 0, 0);   // read-after-write back to back
    txn(0, 0, 1, 9, 0,    0, 0);
    txn(0, 1, 0, 2, 4'hC, 0, 1);   // reset mid-WAIT aborts
    txn(0, 0, 1, 2, 0,    0, 0);   // still 0 after abort
    rand_txns(0, 40);

    // LATENCY=0 instance
    txn(1, 1, 0, 4, 4'h6, 1, 0);   // parity injected when the feature is built
    txn(1, 0, 1, 4, 0,    0, 0);
    txn(1, 1, 1, 8, 4'h5, 0, 0);
    txn(1, 1, 0, 4, 4'h9, 0, 0);   // clean rewrite clears the injected error
    txn(1, 0, 1, 4, 0,    0, 0);
    rand_txns(1, 40);

    repeat (3) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_dmem_responder

`default_nettype wire
